// File: rtl/counter_8b_updown_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants for the up/down counter slice.
//   CNT_WIDTH  : default counter width
//   DIR_UP     : dir level selecting +1
//   DIR_DOWN   : dir level selecting -1
//   RST_ACTIVE : rst level that clears the count
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int   CNT_WIDTH  = 8;
    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;
    localparam logic RST_ACTIVE = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_8b_updown_if.sv
// -----------------------------------------------------------------------------
// counter_8b_updown_if
// Bundles the counter's data-side signals for whoever drives and observes it.
//   dir   : direction select (1 = up, 0 = down)
//   count : current counter value
// Modports:
//   master : owner of dir, observer of count (the surrounding logic)
//   slave  : consumer of dir, producer of count (the counter itself)
// -----------------------------------------------------------------------------
interface counter_8b_updown_if #(
    parameter int WIDTH = 8
);

    logic             dir;
    logic [WIDTH-1:0] count;

    modport master (output dir, input count);
    modport slave  (input dir, output count);

endinterface : counter_8b_updown_if

// File: rtl/counter_8b_updown_chk.sv
// -----------------------------------------------------------------------------
// counter_8b_updown_chk
// Simulation-only property checker, attached to every counter_8b_updown
// instance through a bind so the counter itself carries no checking logic.
//   clk, rst, dir, count : observed copies of the counter's ports
// Properties:
//   - count is 0 on the edge after an edge with rst asserted
//   - once reset has been seen, every non-reset edge moves count by
//     exactly +1 (dir up) or -1 (dir down) modulo 2^WIDTH
// -----------------------------------------------------------------------------
module counter_8b_updown_chk
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input logic             clk,
    input logic             rst,
    input logic             dir,
    input logic [WIDTH-1:0] count
);

    // The count is undefined until the first clocked reset; the step
    // property is only meaningful after one has been observed.
    logic seen_reset_q;

    // Latch that a reset edge has occurred.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            seen_reset_q <= 1'b1;
        end else begin
            seen_reset_q <= seen_reset_q;
        end
    end

    a_reset_clears : assert property (
        @(posedge clk) (rst == RST_ACTIVE) |=> (count == '0)
    );

    a_step_by_one : assert property (
        @(posedge clk) (seen_reset_q && (rst != RST_ACTIVE)) |=>
            (count == ($past(count) +
                       (($past(dir) == DIR_UP) ? WIDTH'(1) : {WIDTH{1'b1}})))
    );

endmodule : counter_8b_updown_chk

bind counter_8b_updown counter_8b_updown_chk #(
    .WIDTH (WIDTH)
) u_counter_chk (
    .clk   (clk),
    .rst   (rst),
    .dir   (dir),
    .count (count)
);

// File: rtl/counter_8b_updown_step.sv
// -----------------------------------------------------------------------------
// updown_step
// Combinational WIDTH-bit +/-1 unit, wrapping modulo 2^WIDTH.
//   value_i : current value
//   dir_i   : 1 = increment, 0 = decrement
//   next_o  : value_i +/- 1, truncated to WIDTH bits
// -----------------------------------------------------------------------------
module updown_step
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] next_o
);

    // Increment or decrement; truncation to WIDTH bits provides the wrap.
    always_comb begin
        next_o = value_i;
        if (dir_i == DIR_UP) begin
            next_o = value_i + WIDTH'(1);
        end else begin
            next_o = value_i - WIDTH'(1);
        end
    end

endmodule : updown_step

// File: rtl/counter_8b_updown.sv
// -----------------------------------------------------------------------------
// counter_8b_updown
// Free-running WIDTH-bit binary up/down counter with synchronous active-low
// reset. Each rising clk edge clears the count (rst low) or moves it one
// step in the direction given by dir, wrapping modulo 2^WIDTH.
//   count : current value, driven straight from the register
//   clk   : clock, rising-edge active
//   rst   : synchronous reset, active low
//   dir   : 1 = count up, 0 = count down
// -----------------------------------------------------------------------------
module counter_8b_updown
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    output logic [WIDTH-1:0] count,
    input  logic             clk,
    input  logic             rst,
    input  logic             dir
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    updown_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value_i (count_q),
        .dir_i   (dir),
        .next_o  (count_d)
    );

    // Count register; reset takes priority over the step.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : counter_8b_updown

// File: tb/tb_counter_8b_updown.sv
// -----------------------------------------------------------------------------
// tb_counter_8b_updown
// Driver pushes the expected count for each edge into a queue; a separate
// monitor pops and compares shortly after every rising edge. The reference
// model is plain modulo-256 arithmetic on an integer.
// -----------------------------------------------------------------------------
module tb_counter_8b_updown;

    localparam int W = 8;

    logic clk;
    logic rst;

    counter_8b_updown_if #(.WIDTH(W)) cnt_if ();

    counter_8b_updown #(
        .WIDTH (W)
    ) dut (
        .count (cnt_if.count),
        .clk   (clk),
        .rst   (rst),
        .dir   (cnt_if.dir)
    );

    int unsigned exp_q[$];
    int          model_val;
    int          tests;
    int          errors;
    int          edge_no;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one edge's inputs and record what the count must become.
    task automatic drive(input logic r, input logic d);
        @(negedge clk);
        rst        = r;
        cnt_if.dir = d;
        if (r == 1'b0) begin
            model_val = 0;
        end else if (d == 1'b1) begin
            model_val = (model_val + 1) % 256;
        end else begin
            model_val = (model_val + 255) % 256;
        end
        exp_q.push_back(model_val);
    endtask

    // Monitor: compare each edge's result against the oldest expectation.
    initial begin
        edge_no = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                int unsigned e;
                e = exp_q.pop_front();
                tests++;
                edge_no++;
                if (cnt_if.count !== W'(e)) begin
                    errors++;
                    $display("FAIL count edge %0d: got %0d expected %0d",
                             edge_no, cnt_if.count, e);
                end
            end
        end
    end

    initial begin
        tests      = 0;
        errors     = 0;
        model_val  = 0;
        rst        = 1'b0;
        cnt_if.dir = 1'b1;

        // Reset held for two edges with dir up.
        repeat (2) drive(1'b0, 1'b1);

        // Up count through the wrap: 1..255, 0, 1, 2.
        repeat (258) drive(1'b1, 1'b1);

        // Down count through the wrap: 255..0, 255.
        drive(1'b0, 1'b1);
        repeat (257) drive(1'b1, 1'b0);

        // Direction change: up to 10, down to 7, up to 8.
        drive(1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);

        // Reset mid-count at 200 with dir switched down, then 255, 254.
        drive(1'b0, 1'b1);
        repeat (200) drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        repeat (2) drive(1'b1, 1'b0);

        // Random direction with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)));
        end

        // Let the monitor drain, with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(posedge clk);
        end
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule : tb_counter_8b_updown

// File: doc/counter_8b_updown.md
# counter_8b_updown

Free-running 8-bit binary up/down counter with a direction select and synchronous reset. Every rising clock edge moves the count one step up or down, wrapping modulo 256. It is a standalone leaf block that supplies a count value to surrounding logic and to simulation monitors. The count is a plain register output with no handshake.

## Interface
- WIDTH, default 8: counter width in bits. Only 8 is verified. The RTL must be written width-generic.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-low; count is cleared on any rising clk edge where rst==0.
- count  output  WIDTH  current counter value, driven directly from the register.
- dir  input  1  direction select: 1 = count up (+1), 0 = count down (−1).
- Instantiation port order is (count, clk, rst, dir).

## Operation
- A single WIDTH-bit register holds the count, and count is that register.
- Rising clk edge, priority order:
  - rst==0: count ← 0, regardless of dir.
  - else dir==1: count ← count + 1 mod 2^WIDTH.
  - else: count ← count − 1 mod 2^WIDTH.
- Wrap-around:
  - up from 255 gives 0;
  - down from 0 gives 255;
  - no saturation, no carry/borrow output.
- Arithmetic is unsigned and truncated to WIDTH bits. No intermediate wider result is visible at the output.
- dir is sampled only at the clock edge. A change of dir takes effect on the next edge, with no idle or penalty cycle.
- Reset during counting: the count is forced to 0 at the first edge with rst low. It stays 0 while rst is held low. Counting resumes from 0 on the first edge after rst returns high, in the direction given by dir at that edge.
- Before the first clocked reset the count value is undefined (X in simulation). No initial-value reliance.
- dir and rst X/Z are not supported; both must be driven to known levels.

## Timing
- Latency from input to count is one clock edge.
- After rst is released, the first edge yields 1 (dir=1) or 255 (dir=0).
- A full up cycle returns to 0 after 256 edges. The same holds for a full down cycle.
- Output changes only on the rising clk edge. There are no combinational paths from any input to count.
- The design is single clock domain. Synchronizing rst or dir to clk is the responsibility of external logic.

## Structure
- Shared package `counter_pkg` holds:
  - default width constant CNT_WIDTH = 8;
  - direction encodings DIR_UP = 1'b1 and DIR_DOWN = 1'b0;
  - reset-asserted level RST_ACTIVE = 1'b0.
- One natural sub-module, `updown_step`: a combinational WIDTH-bit ±1 unit (inputs value and dir, output next value, modulo 2^WIDTH).
- The top level holds only the register, the reset mux and the `updown_step` instance.
- Include assertions (simulation-only) in the RTL:
  - count==0 on the edge after rst low;
  - count steps by exactly ±1 mod 256 per edge otherwise.

## Test plan
- Reset: hold rst=0 for 2 edges with dir=1 -> count==0 after the first edge and remains 0.
- Up count and wrap: release rst with dir=1 and run 258 edges -> count reads 1,2,…,255,0,1,2 on successive edges.
- Down count and wrap: after reset, dir=0 -> count reads 255, 254, … 1, 0, then 255.
- Direction change: up to 10, then set dir=0 -> next edges give 9, 8, 7. Set dir=1 at 7 -> next edge gives 8.
- Reset mid-operation: during up-count at ~200, assert rst=0 for 1 edge with dir switched to 0 -> count==0, then 255, 254 after release.
- Monitor check: on every edge without reset, (count_new − count_old) mod 256 equals +1 if dir=1, else 255.
